// File: rtl/ras_pkg.sv
// ras_pkg: shared definitions for the checkpointed return address stack.
//   RAS_DEPTH_W : pointer width for the default stack depth
//   RAS_CKPT_W  : checkpoint slot index width for the default slot count
//   ras_ckpt_t  : one recovery record {ptr, count, top}
// The record layout follows the package defaults. Overriding the ras_ckpt
// parameters away from these defaults also requires updating this package.
package ras_pkg;

    localparam int RAS_XLEN     = 32;
    localparam int RAS_DEPTH    = 16;
    localparam int RAS_NUM_CKPT = 4;
    localparam int RAS_DEPTH_W  = $clog2(RAS_DEPTH);
    localparam int RAS_CKPT_W   = $clog2(RAS_NUM_CKPT);

    typedef struct packed {
        logic [RAS_DEPTH_W-1:0] ptr;    // next free slot
        logic [RAS_DEPTH_W:0]   count;  // occupancy, 0..DEPTH
        logic [RAS_XLEN-1:0]    top;    // entry at TOS when captured
    } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_table.sv
// ras_ckpt_table: NUM_CKPT-entry register file of RAS recovery records.
//   clock, reset     : rising-edge clock, synchronous active-low reset
//   we_i/waddr_i/wdata_i : save port, written at the clock edge
//   raddr_i/rdata_o  : combinational restore port; returns the contents
//                      held before any same-cycle save
module ras_ckpt_table
    import ras_pkg::*;
#(
    parameter int NUM_CKPT = RAS_NUM_CKPT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        we_i,
    input  logic [$clog2(NUM_CKPT)-1:0] waddr_i,
    input  ras_ckpt_t                   wdata_i,
    input  logic [$clog2(NUM_CKPT)-1:0] raddr_i,
    output ras_ckpt_t                   rdata_o
);

    ras_ckpt_t slot_q [NUM_CKPT];

    assign rdata_o = slot_q[raddr_i];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CKPT; i++) slot_q[i] <= '0;
        end else if (we_i) begin
            slot_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/ras_ckpt.sv
// ras_ckpt: checkpointed return address stack for the fetch predictor.
//   clock, reset       : rising-edge clock, synchronous active-low reset
//   push, link_pc      : call predicted; pushes link_pc+4
//   pop                : return predicted
//   return_addr, empty : predicted target (entry at TOS) and count==0
//   ckpt_save(_id)     : capture {ptr, count, top} into a slot
//   ckpt_restore(_id)  : one-cycle repair from a slot; overrides push/pop
module ras_ckpt
    import ras_pkg::*;
#(
    parameter int XLEN     = RAS_XLEN,
    parameter int DEPTH    = RAS_DEPTH,
    parameter int NUM_CKPT = RAS_NUM_CKPT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [XLEN-1:0]             link_pc,
    output logic [XLEN-1:0]             return_addr,
    output logic                        empty,
    input  logic                        ckpt_save,
    input  logic [$clog2(NUM_CKPT)-1:0] ckpt_save_id,
    input  logic                        ckpt_restore,
    input  logic [$clog2(NUM_CKPT)-1:0] ckpt_restore_id
);

    localparam int DW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [DW-1:0]   ptr_q, ptr_d;
    logic [DW:0]     count_q, count_d;
    logic [DW-1:0]   tos;
    logic            mem_we;
    logic [DW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] link_addr;
    ras_ckpt_t       save_rec, rest_rec;

    // ptr is DW bits wide, so the subtraction wraps 0 -> DEPTH-1 for free.
    assign tos         = ptr_q - DW'(1);
    assign return_addr = mem_q[tos];
    assign empty       = (count_q == '0);
    assign link_addr   = link_pc + XLEN'(4);

    // Snapshot uses this cycle's pre-update state regardless of other inputs.
    assign save_rec.ptr   = ptr_q;
    assign save_rec.count = count_q;
    assign save_rec.top   = mem_q[tos];

    ras_ckpt_table #(.NUM_CKPT(NUM_CKPT)) u_table (
        .clock   (clock),
        .reset   (reset),
        .we_i    (ckpt_save),
        .waddr_i (ckpt_save_id),
        .wdata_i (save_rec),
        .raddr_i (ckpt_restore_id),
        .rdata_o (rest_rec)
    );

    always_comb begin
        ptr_d     = ptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = link_addr;
        if (ckpt_restore) begin
            // Only the top entry is repaired; deeper entries may be stale.
            ptr_d     = rest_rec.ptr;
            count_d   = rest_rec.count;
            mem_we    = 1'b1;
            mem_waddr = rest_rec.ptr - DW'(1);
            mem_wdata = rest_rec.top;
        end else if (push && pop && !empty) begin
            // Tail call: replace the return target in place.
            mem_we    = 1'b1;
            mem_waddr = tos;
        end else if (push) begin
            // At full the write lands on the oldest entry.
            mem_we  = 1'b1;
            ptr_d   = ptr_q + DW'(1);
            if (count_q != (DW+1)'(DEPTH)) count_d = count_q + (DW+1)'(1);
        end else if (pop && !empty) begin
            ptr_d   = tos;
            count_d = count_q - (DW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Parametrised, checkpointed return address stack for the fetch-stage predictor. It pushes the link address on calls and supplies a predicted target on returns. It saves a recovery checkpoint per in-flight branch and restores pointer, count and top entry in one cycle on a mispredict. It supersedes the fixed 8-entry, non-recoverable RAS, with configurable depth, occupancy tracking, call-return replace, and speculative repair.

## Interface
- XLEN, 32, address width
- DEPTH, 16, stack entries; power of two, ≥2
- NUM_CKPT, 4, checkpoint slots (one per in-flight branch tag)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clock
- push  in  1  call predicted this cycle
- pop  in  1  return predicted this cycle
- link_pc  in  XLEN  PC of the call; pushed value is link_pc+4
- return_addr  out  XLEN  predicted return target = entry at TOS
- empty  out  1  count==0
- ckpt_save  in  1  capture checkpoint this cycle
- ckpt_save_id  in  $clog2(NUM_CKPT)  slot written
- ckpt_restore  in  1  recover from checkpoint this cycle
- ckpt_restore_id  in  $clog2(NUM_CKPT)  slot read

## Operation
- State: mem[DEPTH], ptr (next free slot, log2(DEPTH) bits, modular), count (0..DEPTH, log2(DEPTH)+1 bits).
- TOS index = ptr-1 mod DEPTH. return_addr = mem[TOS] combinationally, even when empty.
- Priority each cycle: restore > push/pop.
- ckpt_restore: ptr, count ← slot.ptr, slot.count. mem[slot.ptr-1] ← slot.top. push/pop that cycle are ignored.
- push only: mem[ptr] ← link_pc+4; ptr+1 wraps DEPTH-1→0; count ← min(count+1, DEPTH). At full, the oldest entry is overwritten silently.
- pop only: if count>0, ptr−1 wraps 0→DEPTH-1 and count−1. If count==0, there is no change (underflow is ignored).
- push and pop together (call-return tail call): if count>0, mem[TOS] ← link_pc+4, with ptr and count unchanged. If count==0, it acts as push.
- ckpt_save: slot[ckpt_save_id] ← {ptr, count, mem[TOS]}, the pre-update values of this cycle. It happens regardless of push/pop/restore the same cycle.
- Save and restore to the same id in one cycle: restore uses the old slot contents; the slot then holds the newly saved value.
- All arithmetic is modulo DEPTH on ptr. count saturates; it never wraps.

## Timing
- Reset (reset==0 at edge): ptr=0, count=0, every mem entry=0, every checkpoint slot={0,0,0}. Hence return_addr=0 and empty=1 from the cycle after reset.
- Reset mid-operation overrides every other input that cycle.
- Push, pop, and restore take effect at the next rising edge. return_addr and empty reflect the new state in the following cycle (1-cycle update latency, 0-cycle read latency).
- There is no handshake; all inputs are single-cycle pulses qualified by the clock edge and are never stalled.
- Checkpoint slots are not invalidated by restore. Stale slots are the caller's responsibility.

## Structure
- Shared package ras_pkg holds:
  - RAS_DEPTH_W and RAS_CKPT_W localparams
  - typedef ras_ckpt_t {ptr, count, top[XLEN-1:0]}
- One sub-module, ras_ckpt_table: a NUM_CKPT×ras_ckpt_t register file with one write port (save) and one combinational read port (restore). It has the same reset rule.
- Stack storage and the pointer/count FSM stay in ras_ckpt. There is no further hierarchy.

## Test plan
- Reset then idle: return_addr=0, empty=1. Push link_pc=0x100, then the next cycle return_addr=0x104 and empty=0. Pop, then empty=1.
- Overflow (DEPTH=16): push 0x0,0x10,…,0x110 (18 calls). count stays at 16. Sixteen pops return 0x114 down to 0x24, then empty=1. A 17th pop changes nothing.
- Simultaneous push+pop with TOS=0x204 and link_pc=0x300: return_addr=0x304 and count is unchanged. The same on empty: count=1 and return_addr=0x304.
- Checkpoint repair: push 0x100 (TOS 0x104), save id 2, pop, then push 0x500 (overwrites the slot). Restore id 2, then return_addr=0x104 with count=1.
- Restore wins over push/pop: restore with push (link_pc 0x700) and pop asserted. The state equals the checkpoint exactly, and 0x704 appears nowhere.
- Save and restore to the same id in one cycle: the restored state is the old slot. Restoring that id again later yields the pre-update state captured in that cycle.
